// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields and status in, datapath controls out
interface multicycle_controller_if;
  logic [6:0] i_operand;
  logic [2:0] i_funct3;
  logic       i_funct7bit5;
  logic       i_zero;
  logic       i_stall;
  logic       o_pcWriteEn;
  logic       o_addrSel;
  logic       o_irWriteEn;
  logic       o_memWriteEn;
  logic       o_regWriteEn;
  logic [1:0] o_aluSrcASel;
  logic [1:0] o_aluSrcBSel;
  logic [3:0] o_aluLogicOperation;
  logic [1:0] o_resultSel;
  logic [1:0] o_immSel;
  logic       o_illegalInstr;
  logic       o_retired;
  modport master (
    output i_operand, i_funct3, i_funct7bit5, i_zero, i_stall,
    input  o_pcWriteEn, o_addrSel, o_irWriteEn, o_memWriteEn, o_regWriteEn,
           o_aluSrcASel, o_aluSrcBSel, o_aluLogicOperation, o_resultSel,
           o_immSel, o_illegalInstr, o_retired
  );
  modport slave (
    input  i_operand, i_funct3, i_funct7bit5, i_zero, i_stall,
    output o_pcWriteEn, o_addrSel, o_irWriteEn, o_memWriteEn, o_regWriteEn,
           o_aluSrcASel, o_aluSrcBSel, o_aluLogicOperation, o_resultSel,
           o_immSel, o_illegalInstr, o_retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: one-micro-step-per-clock sequencer for the multicycle RV32I core
module multicycle_controller (
  input logic i_clk,
  input logic i_arst,
  multicycle_controller_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JALS, BEQS
  } state_t;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_BEQ = 7'b1100011;
  state_t state_q, state_d, next_s;
  logic pc_w, ir_w, mem_w, reg_w, ill, ret, gate;
  logic [3:0] func_op;
  // writes and pulses are suppressed while stalled or held in reset
  assign gate = !bus.i_stall && !i_arst;
  // state register, reset lands directly in FETCH
  always_ff @(posedge i_clk or posedge i_arst)
    if (i_arst) state_q <= FETCH;
    else        state_q <= state_d;
  // ALU operation from funct fields; SUB only reachable from register-register ops
  always_comb begin
    func_op = 4'd0;
    case (bus.i_funct3)
      3'b000:  func_op = (state_q == EXECR && bus.i_funct7bit5) ? 4'd1 : 4'd0;
      3'b001:  func_op = 4'd6;
      3'b010:  func_op = 4'd5;
      3'b100:  func_op = 4'd4;
      3'b101:  func_op = bus.i_funct7bit5 ? 4'd8 : 4'd7;
      3'b110:  func_op = 4'd3;
      3'b111:  func_op = 4'd2;
      default: func_op = 4'd0;
    endcase
  end
  // per-state controls and successor; a stall freezes the state but not the selects
  always_comb begin
    next_s = FETCH;
    pc_w = 1'b0;
    ir_w = 1'b0;
    mem_w = 1'b0;
    reg_w = 1'b0;
    ill = 1'b0;
    ret = 1'b0;
    bus.o_addrSel = 1'b0;
    bus.o_aluSrcASel = 2'b00;
    bus.o_aluSrcBSel = 2'b00;
    bus.o_aluLogicOperation = 4'd0;
    bus.o_resultSel = 2'b00;
    case (state_q)
      FETCH: begin
        ir_w = 1'b1;
        pc_w = 1'b1;
        bus.o_aluSrcBSel = 2'b10;
        bus.o_resultSel = 2'b10;
        next_s = DECODE;
      end
      DECODE: begin
        bus.o_aluSrcASel = 2'b01;
        bus.o_aluSrcBSel = 2'b01;
        next_s = (bus.i_operand == OP_LW || bus.i_operand == OP_SW) ? MEMADR :
                 bus.i_operand == OP_R   ? EXECR :
                 bus.i_operand == OP_I   ? EXECI :
                 bus.i_operand == OP_JAL ? JALS  :
                 bus.i_operand == OP_BEQ ? BEQS  : FETCH;
        ill = next_s == FETCH;
        ret = next_s == FETCH;
      end
      MEMADR: begin
        bus.o_aluSrcASel = 2'b10;
        bus.o_aluSrcBSel = 2'b01;
        next_s = bus.i_operand == OP_SW ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.o_addrSel = 1'b1;
        next_s = MEMWB;
      end
      MEMWB: begin
        bus.o_resultSel = 2'b01;
        reg_w = 1'b1;
        ret = 1'b1;
      end
      MEMWRITE: begin
        bus.o_addrSel = 1'b1;
        mem_w = 1'b1;
        ret = 1'b1;
      end
      EXECR: begin
        bus.o_aluSrcASel = 2'b10;
        bus.o_aluLogicOperation = func_op;
        next_s = ALUWB;
      end
      EXECI: begin
        bus.o_aluSrcASel = 2'b10;
        bus.o_aluSrcBSel = 2'b01;
        bus.o_aluLogicOperation = func_op;
        next_s = ALUWB;
      end
      ALUWB: begin
        reg_w = 1'b1;
        ret = 1'b1;
      end
      JALS: begin
        bus.o_aluSrcASel = 2'b01;
        bus.o_aluSrcBSel = 2'b10;
        pc_w = 1'b1;
        next_s = ALUWB;
      end
      BEQS: begin
        bus.o_aluSrcASel = 2'b10;
        bus.o_aluLogicOperation = 4'd1;
        pc_w = bus.i_zero;
        ret = 1'b1;
      end
      default: next_s = FETCH;
    endcase
    state_d = bus.i_stall ? state_q : next_s;
  end
  assign bus.o_pcWriteEn = pc_w && gate;
  assign bus.o_irWriteEn = ir_w && gate;
  assign bus.o_memWriteEn = mem_w && gate;
  assign bus.o_regWriteEn = reg_w && gate;
  assign bus.o_illegalInstr = ill && gate;
  assign bus.o_retired = ret && gate;
  assign bus.o_immSel = bus.i_operand == OP_SW  ? 2'b01 :
                        bus.i_operand == OP_BEQ ? 2'b10 :
                        bus.i_operand == OP_JAL ? 2'b11 : 2'b00;
endmodule
